move_commit_arbiter: RTL
========================

// Module: move_commit_arbiter
// PURPOSE
// - Owns the authoritative 8x8 stable_board and the curr_player turn flag.
// - Arbitrates move-commit requests from two requesters: the local move-entry path and the remote opponent link.
// - Sequences each accepted move as validate -> clear source -> write destination -> toggle turn.
// - Its stable_board output feeds the local move-entry/display logic.
// PARAMETERS
// - EMPTY_CODE   4'd15  piece code for an empty square
// - START_PLAYER 1'b1   curr_player value after reset or setup (1 = white moves first)
// PORTS
// - CLOCK_50      in   1         system clock; all logic on posedge
// - reset         in   1         asynchronous, active-high reset
// - setup         in   1         level; high = reload initial layout, abort any commit
// - player        in   1         local side: 1 = white (codes 0-5), 0 = black (codes 6-11)
// - loc_req       in   1         local commit request; held until loc_ack
// - loc_src/dst   in   2x6       {row[2:0],col[2:0]} source/destination squares
// - loc_piece     in   4         piece code to place at destination
// - loc_ack       out  1         1-cycle acknowledge pulse
// - rem_req/rem_src/rem_dst/rem_piece/rem_ack   same meaning for the remote requester
// - rej           out  1         1-cycle pulse coincident with an ack when the move is refused
// - stable_board  out  [8][8]x4  committed board
// - curr_player   out  1         side to move
// - busy          out  1         high in every state except IDLE
// BEHAVIOUR
// Reset (async, `reset` = 1)
// - Board: row0 = {6,7,8,9,10,8,7,6}; row1 = 11; rows 2-5 = EMPTY_CODE; row6 = 5; row7 = {0,1,2,3,4,2,1,0}.
// - curr_player = START_PLAYER; all acks, rej and busy = 0; FSM = IDLE.
// Setup (`setup` = 1, sampled each cycle, highest priority)
// - player = 1: reset layout.
// - player = 0: rows 0/1 and 6/7 mirrored (row0 = {0,1,2,3,4,2,1,0}, row1 = 5, row6 = 11, row7 = {6,7,8,9,10,8,7,6}).
// - curr_player = START_PLAYER; FSM forced to IDLE; no ack issued for an aborted commit.
// Turn ownership
// - Local owns the turn when player == curr_player; remote owns it otherwise.
// FSM states: IDLE, CHECK, CLR_SRC, WR_DST, DONE
// - IDLE, cycle T: a req from the turn owner latches src/dst/piece and goes to CHECK.
// - IDLE, cycle T: a req from the non-owner gets ack + rej in cycle T+1, stays in IDLE, board unchanged.
// - Simultaneous owner and non-owner reqs: owner is granted; non-owner is rejected.
// - CHECK (T+1): reject and return to IDLE with ack + rej at T+2 if any of:
//   - src == dst
//   - board[src] == EMPTY_CODE
//   - board[src] does not belong to the mover's side
//   - board[dst] holds a piece of the mover's side
//   - piece > 11
// - CHECK passes -> CLR_SRC (T+2): board[src] <= EMPTY_CODE.
// - WR_DST (T+3): board[dst] <= piece. Captures are implicit overwrites.
// - DONE (T+4): ack pulse (rej = 0); curr_player toggles; updated board visible from T+4.
// - After DONE, return to IDLE at T+5. Accepted-move latency: req at T -> ack at T+4.
// Requester handshake
// - A requester must drop req in the cycle after ack; a req still high then counts as a new request.
// Bounds and timing
// - Coordinates are 3-bit; no wrap checks needed, all 64 squares are valid.
// - Requests arriving while busy are held un-acked until IDLE.
// - reset asserted mid-commit: immediate async return to the reset layout; a half-written move is discarded.
// CONFIGURATION
// - CAPTURE_LOG_EN defined: adds outputs cap_valid (1), cap_piece (4), cap_cnt_w (4), cap_cnt_b (4).
//   - In WR_DST, if board[dst] != EMPTY_CODE: cap_valid pulses at T+4 and cap_piece = old board[dst].
//   - The capturing side's counter increments and saturates at 15.
//   - Counters clear on reset and on setup.
// - CAPTURE_LOG_EN undefined: these ports and their logic are absent; all other behaviour is identical.
// TESTING
// 1) Reset, player=1, curr_player=1; loc_req src=(6,4) dst=(4,4) piece=5 -> loc_ack at T+4, rej=0,
//    board[6][4]=15, board[4][4]=5, curr_player=0.
// 2) curr_player=0, player=1; loc_req -> loc_ack + rej at T+1, board unchanged, curr_player stays 0.
// 3) loc_req and rem_req asserted in the same cycle, curr_player=1, player=1 -> rem rejected at T+1;
//    local committed with loc_ack at T+4.
// 4) Remote captures: board[4][4]=5, rem_req src=(1,3) dst=(4,4) piece=11 -> board[4][4]=11;
//    with CAPTURE_LOG_EN: cap_valid=1, cap_piece=5, cap_cnt_b=1.
// 5) Illegal requests: src empty, src==dst, or own-piece destination -> ack + rej at T+2, board unchanged.
// 6) setup pulse in WR_DST -> no ack, layout reloaded per player, curr_player=START_PLAYER;
//    reset asserted mid-commit -> reset layout at once.

Source files
------------

// File: rtl/move_commit_arbiter.sv
// move_commit_arbiter: owns the committed 8x8 board and the side-to-move flag.
// It arbitrates move commits from the local entry path and the remote link, and
// sequences each accepted move as validate, clear source, write destination,
// toggle turn.
// Optional build macro CAPTURE_LOG_EN adds capture reporting outputs
// (cap_valid, cap_piece, cap_cnt_w, cap_cnt_b).
// Piece codes: 0-5 white, 6-11 black, EMPTY_CODE empty. Squares are {row,col}.

module move_commit_arbiter #(
  parameter logic [3:0] EMPTY_CODE   = 4'd15,
  parameter logic       START_PLAYER = 1'b1
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 setup,
  input  logic                 player,
  input  logic                 loc_req,
  input  logic [5:0]           loc_src,
  input  logic [5:0]           loc_dst,
  input  logic [3:0]           loc_piece,
  output logic                 loc_ack,
  input  logic                 rem_req,
  input  logic [5:0]           rem_src,
  input  logic [5:0]           rem_dst,
  input  logic [3:0]           rem_piece,
  output logic                 rem_ack,
  output logic                 rej,
  output logic [7:0][7:0][3:0] stable_board,
  output logic                 curr_player,
  output logic                 busy
`ifdef CAPTURE_LOG_EN
  ,
  output logic                 cap_valid,
  output logic [3:0]           cap_piece,
  output logic [3:0]           cap_cnt_w,
  output logic [3:0]           cap_cnt_b
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StClrSrc,
    StWrDst,
    StDone
  } state_e;

  // Starting layout. local_white = 1 puts white on rows 6/7, else mirrored.
  function automatic logic [7:0][7:0][3:0] layout(input logic local_white);
    logic [7:0][7:0][3:0] b;
    logic [7:0][3:0]      back_w;
    // Index 0 is column 0: {0,1,2,3,4,2,1,0} read from column 0 upward.
    back_w = {4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        b[r][c] = EMPTY_CODE;
      end
    end
    for (int c = 0; c < 8; c++) begin
      b[0][c] = local_white ? back_w[c] + 4'd6 : back_w[c];
      b[1][c] = local_white ? 4'd11 : 4'd5;
      b[6][c] = local_white ? 4'd5 : 4'd11;
      b[7][c] = local_white ? back_w[c] : back_w[c] + 4'd6;
    end
    return b;
  endfunction

  // True when code is a piece of the given side (1 = white).
  function automatic logic of_side(input logic [3:0] code, input logic white);
    if (white) begin
      return code <= 4'd5;
    end
    return (code >= 4'd6) && (code <= 4'd11);
  endfunction

  state_e               r_state;
  state_e               w_state_d;
  logic [7:0][7:0][3:0] r_board;
  logic                 r_curr_player;
  logic [5:0]           r_src;
  logic [5:0]           r_dst;
  logic [3:0]           r_piece;
  logic                 r_from_loc;
  logic                 r_loc_ack;
  logic                 r_rem_ack;
  logic                 r_rej;

  logic                 w_loc_owns;
  logic [3:0]           w_src_code;
  logic [3:0]           w_dst_code;
  logic                 w_illegal;
  logic                 w_grant;
  logic                 w_grant_loc;
  logic                 w_loc_ack_d;
  logic                 w_rem_ack_d;
  logic                 w_rej_d;
  logic                 w_clr_src;
  logic                 w_wr_dst;

  assign w_loc_owns = (player == r_curr_player);
  assign w_src_code = r_board[r_src[5:3]][r_src[2:0]];
  assign w_dst_code = r_board[r_dst[5:3]][r_dst[2:0]];

  // The mover is always the side to move, whichever requester owns the turn.
  assign w_illegal = (r_src == r_dst)
                   | (w_src_code == EMPTY_CODE)
                   | !of_side(w_src_code, r_curr_player)
                   | of_side(w_dst_code, r_curr_player)
                   | (r_piece > 4'd11);

  assign stable_board = r_board;
  assign curr_player  = r_curr_player;
  assign busy         = (r_state != StIdle);
  assign loc_ack      = r_loc_ack;
  assign rem_ack      = r_rem_ack;
  assign rej          = r_rej;

  // Next-state and per-cycle control decode.
  always_comb begin
    w_state_d   = r_state;
    w_grant     = 1'b0;
    w_grant_loc = 1'b0;
    w_loc_ack_d = 1'b0;
    w_rem_ack_d = 1'b0;
    w_rej_d     = 1'b0;
    w_clr_src   = 1'b0;
    w_wr_dst    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_loc_owns) begin
          if (loc_req) begin
            w_grant     = 1'b1;
            w_grant_loc = 1'b1;
            w_state_d   = StCheck;
          end
          if (rem_req) begin
            w_rem_ack_d = 1'b1;
            w_rej_d     = 1'b1;
          end
        end else begin
          if (rem_req) begin
            w_grant   = 1'b1;
            w_state_d = StCheck;
          end
          if (loc_req) begin
            w_loc_ack_d = 1'b1;
            w_rej_d     = 1'b1;
          end
        end
      end
      StCheck: begin
        if (w_illegal) begin
          w_loc_ack_d = r_from_loc;
          w_rem_ack_d = !r_from_loc;
          w_rej_d     = 1'b1;
          w_state_d   = StIdle;
        end else begin
          w_state_d = StClrSrc;
        end
      end
      StClrSrc: begin
        w_clr_src = 1'b1;
        w_state_d = StWrDst;
      end
      StWrDst: begin
        // Ack is registered here so it lands in DONE with the updated board.
        w_wr_dst    = 1'b1;
        w_loc_ack_d = r_from_loc;
        w_rem_ack_d = !r_from_loc;
        w_state_d   = StDone;
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // FSM state register; setup aborts any commit in flight.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else if (setup) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Board, turn flag, latched request and handshake pulses.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_board       <= layout(1'b1);
      r_curr_player <= START_PLAYER;
      r_src         <= 6'd0;
      r_dst         <= 6'd0;
      r_piece       <= 4'd0;
      r_from_loc    <= 1'b0;
      r_loc_ack     <= 1'b0;
      r_rem_ack     <= 1'b0;
      r_rej         <= 1'b0;
    end else if (setup) begin
      r_board       <= layout(player);
      r_curr_player <= START_PLAYER;
      r_loc_ack     <= 1'b0;
      r_rem_ack     <= 1'b0;
      r_rej         <= 1'b0;
    end else begin
      r_loc_ack <= w_loc_ack_d;
      r_rem_ack <= w_rem_ack_d;
      r_rej     <= w_rej_d;
      if (w_grant) begin
        r_src      <= w_grant_loc ? loc_src : rem_src;
        r_dst      <= w_grant_loc ? loc_dst : rem_dst;
        r_piece    <= w_grant_loc ? loc_piece : rem_piece;
        r_from_loc <= w_grant_loc;
      end
      if (w_clr_src) begin
        r_board[r_src[5:3]][r_src[2:0]] <= EMPTY_CODE;
      end
      if (w_wr_dst) begin
        r_board[r_dst[5:3]][r_dst[2:0]] <= r_piece;
        r_curr_player                   <= ~r_curr_player;
      end
    end
  end

`ifdef CAPTURE_LOG_EN
  logic       r_cap_valid;
  logic [3:0] r_cap_piece;
  logic [3:0] r_cap_cnt_w;
  logic [3:0] r_cap_cnt_b;
  logic       w_cap_hit;

  // A capture is any destination write over an occupied square.
  assign w_cap_hit = w_wr_dst && (w_dst_code != EMPTY_CODE);

  assign cap_valid = r_cap_valid;
  assign cap_piece = r_cap_piece;
  assign cap_cnt_w = r_cap_cnt_w;
  assign cap_cnt_b = r_cap_cnt_b;

  // Capture pulse, captured piece and saturating per-side capture counters.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_cap_valid <= 1'b0;
      r_cap_piece <= 4'd0;
      r_cap_cnt_w <= 4'd0;
      r_cap_cnt_b <= 4'd0;
    end else if (setup) begin
      r_cap_valid <= 1'b0;
      r_cap_piece <= 4'd0;
      r_cap_cnt_w <= 4'd0;
      r_cap_cnt_b <= 4'd0;
    end else begin
      r_cap_valid <= w_cap_hit;
      if (w_cap_hit) begin
        r_cap_piece <= w_dst_code;
        if (r_curr_player) begin
          if (r_cap_cnt_w != 4'd15) begin
            r_cap_cnt_w <= r_cap_cnt_w + 4'd1;
          end
        end else begin
          if (r_cap_cnt_b != 4'd15) begin
            r_cap_cnt_b <= r_cap_cnt_b + 4'd1;
          end
        end
      end
    end
  end
`endif

endmodule
